evt_refresh_scheduler: RTL and testbench
========================================

Name: evt_refresh_scheduler

Overview:
- Controls when UPDATE (neuron refresh) events are inserted into the SNE time/spike event stream.
- Tracks the current stream time and the time of the last refresh.
- Inserts an UPDATE event ahead of any TIME event that is at least a programmable period past the last refresh. Also serves software refresh requests over a req/ack pulse pair.
- Sits between the event source (sequencer/DMA side) and the engine-side time stream consumer.

Parameters:
- TIME_W, 28: width of timestamp.value and of all internal time registers.
- CNT_W, 16: width of refresh_count_o.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- enable_i  input  1  scheduler enable. Low means pure passthrough, no automatic insertion.
- period_i  input  TIME_W  refresh period in time units. 0 disables automatic refresh.
- sw_refresh_req_i  input  1  single-cycle pulse requesting one UPDATE insertion
- sw_refresh_ack_o  output  1  single-cycle pulse on the UPDATE handshake that serviced a pending software request
- refresh_count_o  output  CNT_W  number of UPDATE events emitted, wraps modulo 2^CNT_W
- evt_stream_dst  SNE_EVENT_STREAM.dst  -  input event stream (valid/ready/evt)
- evt_stream_src  SNE_EVENT_STREAM.src  -  output event stream

Behaviour:
- Reset values:
  - state = IDLE.
  - last_refresh_q = 0, cur_time_q = 0, sw_pend_q = 0, out_stall_q = 0.
  - refresh_count_o = 0, sw_refresh_ack_o = 0.
- UPDATE event = {EVT_UPDATE, zeros}, with the same encoding as the package constant.
- is_time = dst.valid & operation == EVT_TIME; t = timestamp.value.
- delta = t - last_refresh_q, computed modulo 2^TIME_W, so wrap-around is handled naturally.
- auto_due = enable_i & is_time & (period_i != 0) & (delta >= period_i).
- out_stall_q is set when src.valid & ~src.ready at a clock edge. Once valid is raised, the output event must stay stable until ready.
- IDLE:
  - Default is combinational passthrough: src = dst, dst.ready = src.ready, zero latency.
  - If auto_due: drop dst.ready and src.valid (pause), go to INSERT, set origin = AUTO.
  - Else if sw_pend_q & enable_i & ~out_stall_q: pause, go to INSERT, set origin = SW. This has priority over forwarding a non-due input.
  - Each TIME handshake in passthrough sets cur_time_q <= t.
- INSERT:
  - Drive src.valid = 1, src.evt = UPDATE, dst.ready = 0.
  - Wait for src.ready. On the handshake:
    - refresh_count_o increments.
    - If sw_pend_q: sw_refresh_ack_o = 1 next cycle and sw_pend_q clears. An AUTO insertion also satisfies a pending software request.
    - origin AUTO: last_refresh_q <= t (the held TIME value), go to FORWARD.
    - origin SW: last_refresh_q <= cur_time_q, go to IDLE.
  - enable_i falling in INSERT does not abort; the insertion completes.
- FORWARD:
  - Passthrough of the held TIME event.
  - On the handshake: cur_time_q <= t, go to IDLE.
  - The auto_due check is suppressed in this state, so each TIME event gets at most one insertion.
- sw_refresh_req_i:
  - Sets sw_pend_q.
  - A request in the same cycle as the clearing handshake leaves sw_pend_q set; set wins.
  - Further requests while pending merge into one.
- enable_i low in IDLE: passthrough only. sw_pend_q is retained and serviced once enable returns.
- Latency:
  - Passthrough: 0 cycles.
  - Insertion: 1 UPDATE beat, then the original event. Minimum 2 cycles with ready constantly high.
- Spike events never trigger insertion. They pass unchanged.
- Asynchronous reset mid-operation returns to IDLE and discards any in-flight insertion and pending request.
- Illegal state encoding: go to IDLE.

Decomposition:
- sne_evt_stream_pkg holds the shared types and constants:
  - the state enum type evt_refresh_sched_state_t;
  - the UPDATE event constant, built from EVT_UPDATE, EVENT_WIDTH and OP_WIDTH;
  - spike_t, EVT_TIME and EVT_UPDATE, used as already defined.
- No sub-module. The modular delta comparison stays inline.

Test Plan:
- Auto refresh: period=256. Send TIME 100, then TIME 300 with ready=1 → first passes in 0 cycles; second is preceded by exactly one UPDATE. last_refresh=300, refresh_count=1.
- Below period: after last_refresh=300, send TIME 555 → no insertion. Then TIME 556 → UPDATE is inserted (delta=256 counts as due).
- Wrap-around: last_refresh=0x0FFFFF80, period=256. TIME 0x00000050 (delta=0xD0) → no insert. TIME 0x00000080 (delta=0x100) → UPDATE inserted.
- Software request:
  - Pulse req with the input idle → UPDATE emitted; ack pulses once; count increments; last_refresh=cur_time.
  - Two req pulses before service → only one UPDATE and one ack.
- Backpressure: hold src.ready=0 during INSERT for 5 cycles while pulsing req and toggling enable → UPDATE stays valid and stable. After ready, the TIME event follows unchanged. The req is merged (one ack), with no dropped or duplicated events.
- period=0 or enable=0: stream of TIME 0, 1000, 5000 with spikes in between → output bit-identical to input, count stays 0. Asserting reset mid-INSERT → all outputs return to reset values.

Source files
------------

// File: rtl/sne_evt_stream_pkg.sv
// Shared event-stream types and constants for the SNE time/spike stream,
// plus the refresh scheduler state and origin encodings.
package sne_evt_stream_pkg;

  localparam int unsigned EVENT_WIDTH = 32;
  localparam int unsigned OP_WIDTH    = 4;
  localparam int unsigned TS_WIDTH    = EVENT_WIDTH - OP_WIDTH;

  // Operation codes carried in the top bits of every event.
  localparam logic [OP_WIDTH-1:0] EVT_SPIKE  = 4'h0;
  localparam logic [OP_WIDTH-1:0] EVT_TIME   = 4'h1;
  localparam logic [OP_WIDTH-1:0] EVT_UPDATE = 4'h2;

  typedef struct packed {
    logic [TS_WIDTH-1:0] value;
  } timestamp_t;

  // For spikes the timestamp field carries the spike payload unchanged.
  typedef struct packed {
    logic [OP_WIDTH-1:0] operation;
    timestamp_t          timestamp;
  } spike_t;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_INSERT  = 2'd1,
    SCHED_FORWARD = 2'd2
  } evt_refresh_sched_state_t;

  typedef enum logic {
    ORIGIN_AUTO = 1'b0,
    ORIGIN_SW   = 1'b1
  } refresh_origin_t;

  // Neuron refresh event: UPDATE opcode with an all-zero body.
  localparam spike_t UPDATE_EVT = spike_t'({EVT_UPDATE, {TS_WIDTH{1'b0}}});

  function automatic logic is_time_evt(input spike_t e);
    return e.operation == EVT_TIME;
  endfunction

endpackage

// File: rtl/sne_event_stream_if.sv
// Event stream bundle. Handshake: a beat transfers on a rising clock edge
// where valid and ready are both high; once valid is raised the producer
// holds evt stable until that edge, and valid never depends on ready.
interface SNE_EVENT_STREAM;
  import sne_evt_stream_pkg::*;

  logic   valid;
  logic   ready;
  spike_t evt;

  modport src (output valid, output evt, input ready);
  modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_refresh_scheduler.sv
// Inserts UPDATE (neuron refresh) events into the SNE time/spike stream,
// either ahead of a TIME event a full period past the last refresh, or on a
// software request. Otherwise the stream passes through with zero latency.
module evt_refresh_scheduler
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned TIME_W = 28,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [TIME_W-1:0]        period_i,
  input  logic                     sw_refresh_req_i,
  output logic                     sw_refresh_ack_o,
  output logic [CNT_W-1:0]         refresh_count_o,
  output evt_refresh_sched_state_t state_o,
  SNE_EVENT_STREAM.dst             evt_stream_dst,
  SNE_EVENT_STREAM.src             evt_stream_src
);

  evt_refresh_sched_state_t state_q, state_d;
  refresh_origin_t          origin_q, origin_d;
  logic [TIME_W-1:0]        last_refresh_q, last_refresh_d;
  logic [TIME_W-1:0]        cur_time_q, cur_time_d;
  logic                     sw_pend_q, sw_pend_d;
  logic                     out_stall_q, out_stall_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     ack_q, ack_d;

  logic                     is_time;
  logic [TIME_W-1:0]        t;
  logic [TIME_W-1:0]        delta;
  logic                     auto_due;
  logic                     sw_go;
  logic                     sw_clear;
  logic                     src_valid;
  spike_t                   src_evt;
  logic                     dst_ready;

  assign is_time = evt_stream_dst.valid & is_time_evt(evt_stream_dst.evt);
  assign t       = evt_stream_dst.evt.timestamp.value;
  // Modular subtraction: a timestamp that wrapped past zero still yields
  // the true forward distance from the last refresh.
  assign delta   = t - last_refresh_q;
  // A stalled output beat must stay put, so no new decision is taken while
  // the previous cycle ended with valid high and ready low.
  assign auto_due = enable_i & is_time & (period_i != '0) & (delta >= period_i)
                    & ~out_stall_q;
  assign sw_go    = sw_pend_q & enable_i & ~out_stall_q;

  // Next-state, stream muxing and bookkeeping for the insertion FSM.
  always_comb begin
    state_d        = state_q;
    origin_d       = origin_q;
    last_refresh_d = last_refresh_q;
    cur_time_d     = cur_time_q;
    count_d        = count_q;
    ack_d          = 1'b0;
    sw_clear       = 1'b0;
    src_valid      = evt_stream_dst.valid;
    src_evt        = evt_stream_dst.evt;
    dst_ready      = evt_stream_src.ready;

    case (state_q)
      SCHED_IDLE: begin
        if (auto_due) begin
          src_valid = 1'b0;
          dst_ready = 1'b0;
          origin_d  = ORIGIN_AUTO;
          state_d   = SCHED_INSERT;
        end else if (sw_go) begin
          src_valid = 1'b0;
          dst_ready = 1'b0;
          origin_d  = ORIGIN_SW;
          state_d   = SCHED_INSERT;
        end else if (is_time && evt_stream_src.ready) begin
          cur_time_d = t;
        end
      end
      SCHED_INSERT: begin
        src_valid = 1'b1;
        src_evt   = UPDATE_EVT;
        dst_ready = 1'b0;
        if (evt_stream_src.ready) begin
          count_d = count_q + 1'b1;
          // Any insertion satisfies a pending software request.
          if (sw_pend_q) begin
            ack_d    = 1'b1;
            sw_clear = 1'b1;
          end
          if (origin_q == ORIGIN_AUTO) begin
            last_refresh_d = t;
            state_d        = SCHED_FORWARD;
          end else begin
            last_refresh_d = cur_time_q;
            state_d        = SCHED_IDLE;
          end
        end
      end
      SCHED_FORWARD: begin
        // The held TIME event goes out as-is; no second due check on it.
        if (evt_stream_dst.valid && evt_stream_src.ready) begin
          if (is_time) cur_time_d = t;
          state_d = SCHED_IDLE;
        end
      end
      default: begin
        src_valid = 1'b0;
        dst_ready = 1'b0;
        state_d   = SCHED_IDLE;
      end
    endcase

    // A new request in the clearing cycle keeps the pending flag set.
    sw_pend_d   = (sw_pend_q & ~sw_clear) | sw_refresh_req_i;
    out_stall_d = src_valid & ~evt_stream_src.ready;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= SCHED_IDLE;
      origin_q       <= ORIGIN_AUTO;
      last_refresh_q <= '0;
      cur_time_q     <= '0;
      sw_pend_q      <= 1'b0;
      out_stall_q    <= 1'b0;
      count_q        <= '0;
      ack_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      origin_q       <= origin_d;
      last_refresh_q <= last_refresh_d;
      cur_time_q     <= cur_time_d;
      sw_pend_q      <= sw_pend_d;
      out_stall_q    <= out_stall_d;
      count_q        <= count_d;
      ack_q          <= ack_d;
    end
  end

  assign evt_stream_src.valid = src_valid;
  assign evt_stream_src.evt   = src_evt;
  assign evt_stream_dst.ready = dst_ready;
  assign sw_refresh_ack_o     = ack_q;
  assign refresh_count_o      = count_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_evt_refresh_scheduler.sv
// Directed bench for evt_refresh_scheduler: auto refresh, period boundary,
// timestamp wrap, software requests, backpressure, passthrough and reset.
module tb_evt_refresh_scheduler;
  import sne_evt_stream_pkg::*;

  localparam logic [31:0] UPD_W = 32'h2000_0000;

  logic                     clk;
  logic                     rst_n;
  logic                     enable;
  logic [27:0]              period;
  logic                     req;
  logic                     ack;
  logic [15:0]              count;
  evt_refresh_sched_state_t state;

  SNE_EVENT_STREAM in_if ();
  SNE_EVENT_STREAM out_if ();

  int tests_run = 0;
  int fails     = 0;
  int ack_seen  = 0;
  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];

  evt_refresh_scheduler #(.TIME_W(28), .CNT_W(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .period_i         (period),
    .sw_refresh_req_i (req),
    .sw_refresh_ack_o (ack),
    .refresh_count_o  (count),
    .state_o          (state),
    .evt_stream_dst   (in_if),
    .evt_stream_src   (out_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records accepted beats and ack pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_if.valid && out_if.ready) out_q.push_back(out_if.evt);
      if (ack) ack_seen++;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [27:0] v);
    return {op, v};
  endfunction

  // Driver: present one event and wait for it to be accepted.
  task automatic send(input logic [3:0] op, input logic [27:0] v, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    in_if.valid = 1'b1;
    in_if.evt   = mk(op, v);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_if.ready) begin
        acc = 1'b1;
        break;
      end
      waits++;
    end
    if (!acc) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout op=%0h value=%0h not accepted in 50 cycles", op, v);
    end
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; period = '0; req = 1'b0;
    in_if.valid = 1'b0; in_if.evt = '0; out_if.ready = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    tests_run++;
    if (state !== SCHED_IDLE || count !== 16'd0 || ack !== 1'b0 || out_if.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs state=%0d count=%0d ack=%0b valid=%0b, required 0/0/0/0",
               state, count, ack, out_if.valid);
    end
    tests_run++;
    if (dut.last_refresh_q !== 28'd0 || dut.cur_time_q !== 28'd0) begin
      fails++;
      $display("FAIL reset_regs last=%0h cur=%0h, required 0/0", dut.last_refresh_q, dut.cur_time_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_auto_refresh;
    int w0, w1;
    enable = 1'b1; period = 28'd256;
    out_q.delete(); exp_q.delete();
    send(EVT_TIME, 28'd100, w0);
    send(EVT_SPIKE, 28'hFFF_FFFF, w1);
    tests_run++;
    if (w0 !== 0 || w1 !== 0) begin
      fails++;
      $display("FAIL auto_passthru_latency time=%0d spike=%0d, required 0/0", w0, w1);
    end
    send(EVT_TIME, 28'd300, w1);
    exp_q = '{mk(EVT_TIME, 28'd100), mk(EVT_SPIKE, 28'hFFF_FFFF), UPD_W, mk(EVT_TIME, 28'd300)};
    tests_run++;
    if (w1 !== 2) begin
      fails++;
      $display("FAIL auto_insert_latency waits=%0d, required 2", w1);
    end
    tests_run++;
    if (out_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL auto_beats count=%0d, required %0d", out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL auto_beat[%0d] got=%h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (dut.last_refresh_q !== 28'd300 || count !== 16'd1) begin
      fails++;
      $display("FAIL auto_state last=%0d count=%0d, required 300/1", dut.last_refresh_q, count);
    end
  endtask

  task automatic test_below_period;
    int w0, w1;
    out_q.delete();
    send(EVT_TIME, 28'd555, w0);
    send(EVT_TIME, 28'd556, w1);
    exp_q = '{mk(EVT_TIME, 28'd555), UPD_W, mk(EVT_TIME, 28'd556)};
    tests_run++;
    if (w0 !== 0 || w1 !== 2) begin
      fails++;
      $display("FAIL boundary_latency delta255=%0d delta256=%0d, required 0/2", w0, w1);
    end
    tests_run++;
    if (out_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL boundary_beats count=%0d, required %0d", out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL boundary_beat[%0d] got=%h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (dut.last_refresh_q !== 28'd556 || count !== 16'd2) begin
      fails++;
      $display("FAIL boundary_state last=%0d count=%0d, required 556/2", dut.last_refresh_q, count);
    end
  endtask

  task automatic test_wrap;
    int w0, w1, w2;
    out_q.delete();
    send(EVT_TIME, 28'hFFF_FF80, w0);
    tests_run++;
    if (dut.last_refresh_q !== 28'hFFF_FF80 || w0 !== 2) begin
      fails++;
      $display("FAIL wrap_setup last=%h waits=%0d, required fffff80/2", dut.last_refresh_q, w0);
    end
    out_q.delete();
    send(EVT_TIME, 28'h000_0050, w1);
    send(EVT_TIME, 28'h000_0080, w2);
    exp_q = '{mk(EVT_TIME, 28'h50), UPD_W, mk(EVT_TIME, 28'h80)};
    tests_run++;
    if (w1 !== 0 || w2 !== 2) begin
      fails++;
      $display("FAIL wrap_latency deltaD0=%0d delta100=%0d, required 0/2", w1, w2);
    end
    tests_run++;
    if (out_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_beats count=%0d, required %0d", out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL wrap_beat[%0d] got=%h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (dut.last_refresh_q !== 28'h80 || count !== 16'd4) begin
      fails++;
      $display("FAIL wrap_state last=%h count=%0d, required 80/4", dut.last_refresh_q, count);
    end
  endtask

  task automatic test_sw_request;
    int w0;
    send(EVT_TIME, 28'h100, w0);
    out_q.delete(); ack_seen = 0;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    idle_cycles(6);
    tests_run++;
    if (out_q.size() != 1 || ack_seen != 1 || count !== 16'd5 || dut.last_refresh_q !== 28'h100) begin
      fails++;
      $display("FAIL sw_single beats=%0d acks=%0d count=%0d last=%h, required 1/1/5/100",
               out_q.size(), ack_seen, count, dut.last_refresh_q);
    end else if (out_q[0] !== UPD_W) begin
      tests_run++;
      fails++;
      $display("FAIL sw_single_evt got=%h, required %h", out_q[0], UPD_W);
    end
    out_q.delete(); ack_seen = 0;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    idle_cycles(6);
    tests_run++;
    if (out_q.size() != 1 || ack_seen != 1 || count !== 16'd6) begin
      fails++;
      $display("FAIL sw_merge beats=%0d acks=%0d count=%0d, required 1/1/6",
               out_q.size(), ack_seen, count);
    end
  endtask

  task automatic test_backpressure;
    out_q.delete(); ack_seen = 0;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.evt    = mk(EVT_TIME, 28'h300);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_if.valid !== 1'b1 || out_if.evt !== UPD_W || in_if.ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d] valid=%0b evt=%h in_ready=%0b, required 1/%h/0",
                 k, out_if.valid, out_if.evt, in_if.ready, UPD_W);
      end
      @(posedge clk); #1;
      req    = (k == 1);
      enable = (k != 2);
    end
    req = 1'b0; enable = 1'b1;
    out_if.ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (in_if.ready !== 1'b1 || out_if.evt !== mk(EVT_TIME, 28'h300)) begin
      fails++;
      $display("FAIL bp_forward in_ready=%0b evt=%h, required 1/%h",
               in_if.ready, out_if.evt, mk(EVT_TIME, 28'h300));
    end
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    idle_cycles(6);
    exp_q = '{UPD_W, mk(EVT_TIME, 28'h300)};
    tests_run++;
    if (out_q.size() != exp_q.size() || ack_seen != 1 || count !== 16'd7) begin
      fails++;
      $display("FAIL bp_result beats=%0d acks=%0d count=%0d, required 2/1/7",
               out_q.size(), ack_seen, count);
    end else begin
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL bp_beat[%0d] got=%h, required %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_insert;
    out_q.delete(); ack_seen = 0;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.evt    = mk(EVT_TIME, 28'h500);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    tests_run++;
    if (state !== SCHED_INSERT) begin
      fails++;
      $display("FAIL rst_pre state=%0d, required %0d", state, SCHED_INSERT);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (state !== SCHED_IDLE || count !== 16'd0 || ack !== 1'b0 || out_if.valid !== 1'b0
        || in_if.ready !== 1'b0 || dut.last_refresh_q !== 28'd0) begin
      fails++;
      $display("FAIL rst_mid state=%0d count=%0d ack=%0b valid=%0b in_ready=%0b last=%h, required 0/0/0/0/0/0",
               state, count, ack, out_if.valid, in_if.ready, dut.last_refresh_q);
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);
    tests_run++;
    if (out_q.size() != 0 || ack_seen != 0) begin
      fails++;
      $display("FAIL rst_discard beats=%0d acks=%0d, required 0/0", out_q.size(), ack_seen);
    end
  endtask

  task automatic test_passthrough;
    logic [3:0]  ops[5];
    logic [27:0] vals[5];
    int w;
    int lat_bad;
    ops  = '{EVT_TIME, EVT_SPIKE, EVT_TIME, EVT_SPIKE, EVT_TIME};
    vals = '{28'd0, 28'h0AB_CDEF, 28'd1000, 28'hFFF_FFFF, 28'd5000};
    for (int pass = 0; pass < 2; pass++) begin
      enable = (pass == 1);
      period = (pass == 1) ? 28'd0 : 28'd256;
      out_q.delete(); exp_q.delete();
      lat_bad = 0;
      for (int i = 0; i < 5; i++) begin
        send(ops[i], vals[i], w);
        if (w != 0) lat_bad++;
        exp_q.push_back(mk(ops[i], vals[i]));
      end
      tests_run++;
      if (lat_bad != 0 || count !== 16'd0 || out_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL passthru[%0d] late=%0d count=%0d beats=%0d, required 0/0/5",
                 pass, lat_bad, count, out_q.size());
      end else begin
        foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL passthru[%0d]_beat[%0d] got=%h, required %h", pass, i, out_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_refresh();
    test_below_period();
    test_wrap();
    test_sw_request();
    test_backpressure();
    test_reset_mid_insert();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
